// File: rtl/data_memory_if.sv
// data_memory_if: requester/responder bus between the data cache and main memory.
// The master side (dcache) raises read or write and holds it until busywait drops.
// The slave side (data_memory) returns a registered block on readdata.
interface data_memory_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busywait;

    modport master (
        output read,
        output write,
        output address,
        output writedata,
        input  readdata,
        input  busywait
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata,
        output busywait
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: block-addressed main data memory serving one requester (dcache).
// Each access takes a fixed LATENCY cycles in BUSY, then one DONE cycle with
// busywait low so the requester can drop or renew its request.
// Optional build macro DMEM_RESET_CLEAR_EN: reset also zeroes every memory word.
// Without it the array keeps its contents across reset.
module data_memory #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 5
) (
    input  logic         clock,
    input  logic         reset,
    data_memory_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [7:0] COUNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic req;
    logic mem_we;
    logic busywait;

    // A request is valid only when exactly one of read/write is asserted.
    assign req = bus.read ^ bus.write;

    assign bus.readdata = readdata_q;
    assign bus.busywait = busywait;

    // Next-state, latch and access decode; busywait is combinational so it
    // rises in the very cycle a request shows up in IDLE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        readdata_d = readdata_q;
        mem_we     = 1'b0;
        busywait   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    busywait = 1'b1;
                    op_wr_d  = bus.write;
                    addr_d   = bus.address;
                    wdata_d  = bus.writedata;
                    count_d  = COUNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (count_q != 8'd0) begin
                    count_d = count_q - 8'd1;
                end else begin
                    state_d = DONE;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        readdata_d = mem_q[addr_q];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and the registered read result return to idle values on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 8'd0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    // Latched copies of the request; inputs are not looked at again until IDLE.
    always_ff @(posedge clock) begin
        op_wr_q <= op_wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Storage array; a write still pending when reset arrives is dropped.
    always_ff @(posedge clock) begin
`ifdef DMEM_RESET_CLEAR_EN
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
`else
        if (!reset && mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
`endif
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized scoreboard bench for data_memory.
// A stimulus process issues accesses and pushes the expected completion;
// a monitor pops one entry per completion (busywait falling) and compares.
module tb_data_memory;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int LAT    = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef struct {
        bit          wr;
        logic [31:0] data;
    } exp_t;

    logic clock;
    logic reset;

    data_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd;
    logic [5:0]  pert_addr;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          busy_n = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the spec's rules applied directly to an array.
    task automatic issue(input bit wr, input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        e.wr = wr;
        if (wr) begin
            model[a] = d;
            e.data   = d;
        end else begin
            e.data  = model[a];
            last_rd = model[a];
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input bit perturb, input logic [5:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) check("busy_rise", {31'd0, bus.busywait}, 32'd1);
            if (perturb && n == 3) begin
                pert_addr = 6'($urandom);
                if (pert_addr == a) pert_addr = pert_addr ^ 6'd1;
                bus.address   = pert_addr;
                bus.writedata = $urandom;
            end
        end while (bus.busywait && n < 100);
        if (bus.busywait) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: busywait still 1 after %0d cycles", n);
        end
    endtask

    task automatic access(input bit wr, input logic [5:0] a, input logic [31:0] d,
                          input bit perturb, input bit hold);
        @(posedge clock);
        #1;
        bus.read      = !wr;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = d;
        issue(wr, a, d);
        wait_done(perturb, a);
        if (hold) begin
            bus.address   = a;
            bus.writedata = d;
            issue(wr, a, d);
            wait_done(1'b0, a);
        end
        @(posedge clock);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    // Monitor: counts busywait-high cycles; a fall without reset is one completion.
    always @(negedge clock) begin
        if (reset) begin
            busy_n = 0;
        end else if (bus.busywait) begin
            busy_n++;
        end else if (busy_n != 0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_completion: queue empty, busy %0d cycles", busy_n);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("busy_cycles", busy_n, LAT + 1);
                if (!e.wr) check("readdata", bus.readdata, e.data);
            end
            busy_n = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          wr;
        logic [5:0]  a;
        logic [31:0] d;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        last_rd       = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_busywait", {31'd0, bus.busywait}, 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) access(1'b1, 6'(i), $urandom, 1'b0, 1'b0);

        // Directed write/read, top address read, perturbation during BUSY.
        access(1'b1, 6'h05, 32'hDEADBEEF, 1'b0, 1'b0);
        access(1'b0, 6'h05, 32'h0, 1'b0, 1'b0);
        access(1'b0, 6'h3F, 32'h0, 1'b0, 1'b0);
        access(1'b1, 6'h02, 32'h11111111, 1'b1, 1'b0);
        access(1'b0, 6'h02, 32'h0, 1'b0, 1'b0);
        access(1'b0, pert_addr, 32'h0, 1'b0, 1'b0);

        // read and write both high: nothing happens.
        @(posedge clock);
        #1;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        bus.address   = 6'h05;
        bus.writedata = 32'h0BADF00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("both_busywait", {31'd0, bus.busywait}, 32'd0);
            check("both_readdata", bus.readdata, last_rd);
        end
        @(posedge clock);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        access(1'b0, 6'h05, 32'h0, 1'b0, 1'b0);

        // Reset in the 2nd BUSY cycle of a write: the write is discarded.
        @(posedge clock);
        #1;
        bus.write     = 1'b1;
        bus.address   = 6'h07;
        bus.writedata = 32'hCAFEF00D;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset     = 1'b1;
        bus.write = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        last_rd = '0;
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
        @(negedge clock);
        check("abort_busywait", {31'd0, bus.busywait}, 32'd0);
        check("abort_readdata", bus.readdata, 32'd0);
        access(1'b0, 6'h07, 32'h0, 1'b0, 1'b0);
`ifndef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < 4; i++) access(1'b1, 6'(i), $urandom, 1'b0, 1'b0);
`endif

        // Read held through DONE restarts a second access.
        access(1'b0, 6'h09, 32'h0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom);
            a  = 6'($urandom);
            d  = $urandom;
            access(wr, a, d, 1'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
